// File: rtl/fp_result_decoder.sv
// fp_result_decoder: FIFO-buffered unpacker for packed IEEE-754 single results,
// with saturating counters of exceptional classes seen on accepted words.
module fp_result_decoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [31:0]                inWord,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       outSign,
    output logic [7:0]                 outExponent,
    output logic [23:0]                outMantissa,
    output logic [2:0]                 outClass,
    output logic [$clog2(DEPTH):0]     occupancy,
    input  logic                       clearCounts,
    output logic [CNT_W-1:0]           zeroCount,
    output logic [CNT_W-1:0]           subCount,
    output logic [CNT_W-1:0]           infCount,
    output logic [CNT_W-1:0]           nanCount
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [31:0]   head;
    logic [2:0]    inClass;
    logic          push, pop;

    function automatic logic [2:0] wordClass(input logic [31:0] w);
        return (w[30:23] == 8'd0)   ? ((w[22:0] == 23'd0) ? 3'd0 : 3'd1) :
               (w[30:23] == 8'hFF)  ? ((w[22:0] == 23'd0) ? 3'd3 : (w[22] ? 3'd4 : 3'd5)) :
                                      3'd2;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign inReady     = (occupancy != FULL);
    assign outValid    = (occupancy != '0);
    assign push        = inValid && inReady;
    assign pop         = outValid && outReady;
    assign head        = mem[rdPtr];
    assign inClass     = wordClass(inWord);
    assign outClass    = wordClass(head);
    assign outSign     = head[31];
    assign outExponent = head[30:23];
    assign outMantissa = {outClass == 3'd2, head[22:0]};

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= inWord;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            occupancy <= occupancy + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Clear has priority over a same-cycle push, so that push goes uncounted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zeroCount <= '0;
            subCount  <= '0;
            infCount  <= '0;
            nanCount  <= '0;
        end else if (clearCounts) begin
            zeroCount <= '0;
            subCount  <= '0;
            infCount  <= '0;
            nanCount  <= '0;
        end else if (push) begin
            if (inClass == 3'd0) zeroCount <= satInc(zeroCount);
            if (inClass == 3'd1) subCount <= satInc(subCount);
            if (inClass == 3'd3) infCount <= satInc(infCount);
            if (inClass >= 3'd4) nanCount <= satInc(nanCount);
        end
    end
endmodule

// File: tb/tb_fp_result_decoder.sv
// tb_fp_result_decoder: directed and random checks of fp_result_decoder against
// a queue-based reference model of the FIFO, classifier and counters.
module tb_fp_result_decoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int SAT = 2**CNT_W - 1;

    logic clk = 0, rst_n = 0, inValid = 0, outReady = 0, clearCounts = 0;
    logic [31:0] inWord = 0;
    logic inReady, outValid, outSign;
    logic [7:0] outExponent;
    logic [23:0] outMantissa;
    logic [2:0] outClass;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNT_W-1:0] zeroCount, subCount, infCount, nanCount;

    fp_result_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .inWord(inWord),
        .outValid(outValid), .outReady(outReady), .outSign(outSign),
        .outExponent(outExponent), .outMantissa(outMantissa), .outClass(outClass),
        .occupancy(occupancy), .clearCounts(clearCounts), .zeroCount(zeroCount),
        .subCount(subCount), .infCount(infCount), .nanCount(nanCount)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] q[$];
    int zc = 0, sc = 0, ic = 0, nc = 0;

    function automatic int mClass(input logic [31:0] w);
        int e = int'(w[30:23]);
        int f = int'(w[22:0]);
        if (e == 0) return (f == 0) ? 0 : 1;
        if (e < 255) return 2;
        if (f == 0) return 3;
        return (f >= 2**22) ? 4 : 5;
    endfunction

    function automatic int mMant(input logic [31:0] w);
        return (mClass(w) == 2) ? int'(w[22:0]) + 2**23 : int'(w[22:0]);
    endfunction

    function automatic int bump(input int c);
        return (c < SAT) ? c + 1 : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel();
        chk("occupancy", 32'(occupancy), q.size());
        chk("outValid", 32'(outValid), (q.size() != 0) ? 1 : 0);
        chk("inReady", 32'(inReady), (q.size() != DEPTH) ? 1 : 0);
        chk("zeroCount", 32'(zeroCount), zc);
        chk("subCount", 32'(subCount), sc);
        chk("infCount", 32'(infCount), ic);
        chk("nanCount", 32'(nanCount), nc);
        if (q.size() != 0) begin
            chk("outSign", 32'(outSign), 32'(q[0][31]));
            chk("outExponent", 32'(outExponent), int'(q[0][30:23]));
            chk("outMantissa", 32'(outMantissa), mMant(q[0]));
            chk("outClass", 32'(outClass), mClass(q[0]));
        end
    endtask

    task automatic step();
        bit mPush, mPop;
        int c;
        checkModel();
        mPush = inValid && (q.size() < DEPTH);
        mPop = outReady && (q.size() > 0);
        @(posedge clk);
        c = mClass(inWord);
        if (clearCounts) begin
            zc = 0; sc = 0; ic = 0; nc = 0;
        end else if (mPush) begin
            if (c == 0) zc = bump(zc);
            if (c == 1) sc = bump(sc);
            if (c == 3) ic = bump(ic);
            if (c >= 4) nc = bump(nc);
        end
        if (mPop) void'(q.pop_front());
        if (mPush) q.push_back(inWord);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] w, input logic r, input logic c);
        inValid = v; inWord = w; outReady = r; clearCounts = c;
        step();
    endtask

    task automatic drain();
        repeat (DEPTH + 1) if (q.size() != 0) put(0, 0, 1, 0);
    endtask

    initial begin
        logic [31:0] seq[5] = '{32'h00000000, 32'h80000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001};
        int seqClass[5] = '{0, 1, 3, 4, 5};
        int satExp[5] = '{1, 2, 3, 3, 3};
        logic [31:0] w;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("reset occupancy", 32'(occupancy), 0);
        chk("reset outValid", 32'(outValid), 0);
        chk("reset inReady", 32'(inReady), 1);

        put(1, 32'h3F800000, 0, 0);
        chk("one outValid", 32'(outValid), 1);
        chk("one outSign", 32'(outSign), 0);
        chk("one outExponent", 32'(outExponent), 32'h7F);
        chk("one outMantissa", 32'(outMantissa), 32'h800000);
        chk("one outClass", 32'(outClass), 2);
        chk("one zeroCount", 32'(zeroCount), 0);

        for (int i = 0; i < 5; i++) begin
            put(1, seq[i], 1, 0);
            chk("seq outClass", 32'(outClass), seqClass[i]);
            if (i == 1) chk("sub outMantissa", 32'(outMantissa), 32'h000001);
        end
        drain();
        chk("seq zeroCount", 32'(zeroCount), 1);
        chk("seq subCount", 32'(subCount), 1);
        chk("seq infCount", 32'(infCount), 1);
        chk("seq nanCount", 32'(nanCount), 2);

        for (int i = 0; i < 5; i++) put(1, 32'h40000000 + i, 0, 0);
        chk("full occupancy", 32'(occupancy), 4);
        chk("full inReady", 32'(inReady), 0);
        put(1, 32'h40000004, 1, 0);
        chk("pop-on-full occupancy", 32'(occupancy), 3);
        chk("pop-on-full inReady", 32'(inReady), 1);
        put(1, 32'h40000004, 0, 0);
        chk("refill occupancy", 32'(occupancy), 4);
        drain();

        put(1, 32'h41000000, 0, 0);
        put(1, 32'h42000000, 0, 0);
        put(1, 32'h7FC00000, 1, 1);
        chk("pushpop occupancy", 32'(occupancy), 2);
        chk("pushpop head exponent", 32'(outExponent), 32'h84);
        chk("clear-wins nanCount", 32'(nanCount), 0);
        drain();

        put(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            put(1, 32'h7F800000, 1, 0);
            chk("sat infCount", 32'(infCount), satExp[i]);
        end
        drain();

        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[30:23] = 8'h00;
                1: w[30:23] = 8'hFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) w[22:0] = '0;
            put($urandom_range(0, 2) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
        end
        drain();

        put(1, 32'h00000000, 0, 0);
        put(1, 32'h7F800000, 0, 0);
        put(1, 32'h3F800000, 0, 0);
        chk("pre-reset occupancy", 32'(occupancy), 3);
        #2 rst_n = 0;
        #1;
        chk("async outValid", 32'(outValid), 0);
        chk("async occupancy", 32'(occupancy), 0);
        chk("async zeroCount", 32'(zeroCount), 0);
        chk("async infCount", 32'(infCount), 0);
        q.delete();
        zc = 0; sc = 0; ic = 0; nc = 0;
        @(posedge clk);
        #1 rst_n = 1;
        put(1, 32'hC0000000, 0, 0);
        chk("post-reset outSign", 32'(outSign), 1);
        chk("post-reset outExponent", 32'(outExponent), 32'h80);
        put(0, 0, 1, 0);
        checkModel();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
